// File: rtl/dds_pkg.sv
// Shared definitions for the multi-channel DDS: waveform mode encoding,
// round sequencing states and the square-wave amplitude.
package dds_pkg;

    localparam logic [1:0] MODE_SINE   = 2'd0;
    localparam logic [1:0] MODE_SQUARE = 2'd1;
    localparam logic [1:0] MODE_SAW    = 2'd2;
    localparam logic [1:0] MODE_TRI    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_COMMIT
    } dds_state_e;

    // Square level is one code short of full scale so both polarities are symmetric.
    function automatic int square_amp(input int data_w);
        return (1 << (data_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/dds_wave_map.sv
// Shared waveform shaper: folds a phase onto the quarter-wave ROM address and
// turns the returned ROM word (or the phase itself) into a signed sample.
module dds_wave_map
    import dds_pkg::*;
#(
    parameter int PHASE_W = 22,
    parameter int ROM_AW  = 10,
    parameter int DATA_W  = 16
) (
    input  logic [PHASE_W-1:0] addr_phase_i,
    input  logic [PHASE_W-1:0] phase_i,
    input  logic [1:0]         mode_i,
    input  logic [DATA_W-1:0]  rom_data_i,
    output logic [ROM_AW-1:0]  rom_addr_o,
    output logic [DATA_W-1:0]  sample_o
);

    localparam logic [DATA_W-1:0] AMP = DATA_W'(square_amp(DATA_W));

    // The ROM read is registered, so the address side works on the channel
    // being issued while the shaping side works on the channel one cycle older.
    logic              a_quad;
    logic [ROM_AW-1:0] a_idx;
    logic [ROM_AW:0]   a_mirror;

    assign a_quad   = addr_phase_i[PHASE_W-2];
    assign a_idx    = addr_phase_i[PHASE_W-3 -: ROM_AW];
    assign a_mirror = {1'b1, {ROM_AW{1'b0}}} - {1'b0, a_idx};

    always_comb begin
        rom_addr_o = a_idx;
        if (a_quad) begin
            rom_addr_o = (a_idx == '0) ? {ROM_AW{1'b1}} : a_mirror[ROM_AW-1:0];
        end
    end

    logic              s_bit;
    logic [DATA_W:0]   tri_p;
    logic [DATA_W-1:0] tri_u;

    assign s_bit = phase_i[PHASE_W-1];
    assign tri_p = phase_i[PHASE_W-1 -: DATA_W+1];
    assign tri_u = tri_p[DATA_W] ? ~tri_p[DATA_W-1:0] : tri_p[DATA_W-1:0];

    always_comb begin
        sample_o = '0;
        case (mode_i)
            MODE_SINE:   sample_o = s_bit ? (~rom_data_i + 1'b1) : rom_data_i;
            MODE_SQUARE: sample_o = s_bit ? (~AMP + 1'b1) : AMP;
            MODE_SAW:    sample_o = {~phase_i[PHASE_W-1], phase_i[PHASE_W-2 -: DATA_W-1]};
            default:     sample_o = {~tri_u[DATA_W-1], tri_u[DATA_W-2:0]};
        endcase
    end

endmodule

// File: rtl/sine_rom.sv
// Quarter-wave sine table, 0..+peak over 2^AW entries, with a registered read port.
module sine_rom #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    output logic [DW-1:0] data_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] rom [DEPTH];
    logic [DW-1:0] data_q;

    // Entry a holds round(peak * sin(pi/2 * a / (DEPTH-1))): entry 0 is zero, the last is peak.
    function automatic logic [DW-1:0] sine_entry(input int a);
        real x;
        real term;
        real sum;
        x    = 1.5707963267948966 * a / (DEPTH - 1);
        term = x;
        sum  = x;
        for (int n = 1; n < 10; n++) begin
            term = -term * x * x / ((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return DW'($rtoi(sum * ((2.0 ** (DW - 1)) - 1.0) + 0.5));
    endfunction

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign rom[gi] = sine_entry(gi);
    end

    always_ff @(posedge clk) begin
        data_q <= rom[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/dds_multi.sv
// Time-multiplexed multi-channel DDS: one round per sampling pulse walks every
// channel through the shared ROM and publishes all samples together.
module dds_multi
    import dds_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int PHASE_W  = 22,
    parameter int ROM_AW   = 10,
    parameter int DATA_W   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*PHASE_W-1:0]  k,
    input  logic [CHANNELS*PHASE_W-1:0]  offset,
    input  logic [CHANNELS*2-1:0]        mode,
    input  logic                         sampling_pulse,
    input  logic                         phase_clr,
    output logic [CHANNELS*DATA_W-1:0]   sample,
    output logic                         new_sample_ready,
    output logic                         busy,
    output logic                         overrun
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    dds_state_e state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic            ready_q;
    logic            overrun_q;
    logic            rom_vld_q;
    logic [CH_W-1:0] rom_ch_q;
    logic [CHANNELS*DATA_W-1:0] sample_q;
    logic [CHANNELS*DATA_W-1:0] sh_flat;

    logic [PHASE_W-1:0] ph_arr   [CHANNELS];
    logic [1:0]         mode_arr [CHANNELS];

    logic [ROM_AW-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] map_sample;
    logic              start;

    // The ready cycle still counts as busy, so a pulse there is an overrun.
    assign busy  = (state_q != ST_IDLE) || ready_q;
    assign start = (state_q == ST_IDLE) && sampling_pulse && !ready_q;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    ch_d    = '0;
                end
            end
            ST_ISSUE: begin
                if (ch_q == CH_W'(CHANNELS - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            ST_DRAIN:  state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
            rom_vld_q <= 1'b0;
            rom_ch_q  <= '0;
            sample_q  <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            ready_q   <= (state_q == ST_COMMIT);
            rom_vld_q <= (state_q == ST_ISSUE);
            rom_ch_q  <= ch_q;
            if (state_q == ST_COMMIT) begin
                sample_q <= sh_flat;
            end
            if (sampling_pulse && busy) begin
                overrun_q <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [PHASE_W-1:0] acc_q;
        logic [PHASE_W-1:0] ph_q;
        logic [1:0]         mode_q;
        logic [DATA_W-1:0]  sh_q;
        logic [PHASE_W-1:0] k_ch;
        logic [PHASE_W-1:0] off_ch;
        logic [PHASE_W-1:0] acc_base;

        assign k_ch     = k[gi*PHASE_W +: PHASE_W];
        assign off_ch   = offset[gi*PHASE_W +: PHASE_W];
        // A clear on the start edge makes the round begin from a zero accumulator.
        assign acc_base = phase_clr ? '0 : acc_q;

        always_ff @(posedge clk) begin
            if (!reset) begin
                acc_q  <= '0;
                ph_q   <= '0;
                mode_q <= MODE_SINE;
                sh_q   <= '0;
            end else begin
                if (start) begin
                    acc_q  <= acc_base + k_ch;
                    ph_q   <= acc_base + k_ch + off_ch;
                    mode_q <= mode[gi*2 +: 2];
                end else if (phase_clr) begin
                    acc_q <= '0;
                end
                if (rom_vld_q && (rom_ch_q == CH_W'(gi))) begin
                    sh_q <= map_sample;
                end
            end
        end

        assign ph_arr[gi]                      = ph_q;
        assign mode_arr[gi]                    = mode_q;
        assign sh_flat[gi*DATA_W +: DATA_W]    = sh_q;
    end

    dds_wave_map #(
        .PHASE_W (PHASE_W),
        .ROM_AW  (ROM_AW),
        .DATA_W  (DATA_W)
    ) u_map (
        .addr_phase_i (ph_arr[ch_q]),
        .phase_i      (ph_arr[rom_ch_q]),
        .mode_i       (mode_arr[rom_ch_q]),
        .rom_data_i   (rom_data),
        .rom_addr_o   (rom_addr),
        .sample_o     (map_sample)
    );

    sine_rom #(
        .AW (ROM_AW),
        .DW (DATA_W)
    ) u_rom (
        .clk    (clk),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    assign sample           = sample_q;
    assign new_sample_ready = ready_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_dds_multi.sv
// Directed scoreboard bench for dds_multi with two channels.
module tb_dds_multi;

    localparam int CHANNELS = 2;
    localparam int PHASE_W  = 22;
    localparam int ROM_AW   = 10;
    localparam int DATA_W   = 16;
    localparam int PK       = 32767;
    localparam int P20      = 1 << 20;
    localparam int P21      = 1 << 21;

    logic                        clk = 1'b0;
    logic                        reset = 1'b0;
    logic [CHANNELS*PHASE_W-1:0] k = '0;
    logic [CHANNELS*PHASE_W-1:0] offset = '0;
    logic [CHANNELS*2-1:0]       mode = '0;
    logic                        sampling_pulse = 1'b0;
    logic                        phase_clr = 1'b0;
    logic [CHANNELS*DATA_W-1:0]  sample;
    logic                        new_sample_ready;
    logic                        busy;
    logic                        overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int ready_seen = 0;
    int pushes = 0;
    logic [CHANNELS*DATA_W-1:0] exp_q [$];
    logic [CHANNELS*DATA_W-1:0] mon_exp;

    dds_multi #(
        .CHANNELS (CHANNELS),
        .PHASE_W  (PHASE_W),
        .ROM_AW   (ROM_AW),
        .DATA_W   (DATA_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .k                (k),
        .offset           (offset),
        .mode             (mode),
        .sampling_pulse   (sampling_pulse),
        .phase_clr        (phase_clr),
        .sample           (sample),
        .new_sample_ready (new_sample_ready),
        .busy             (busy),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    // Monitor: every ready pulse consumes one expected sample vector.
    always @(negedge clk) begin
        if (new_sample_ready) begin
            ready_seen++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready: sample=%h, none expected", sample);
            end else begin
                mon_exp = exp_q.pop_front();
                if (sample !== mon_exp) begin
                    n_fail++;
                    $display("FAIL round_sample: got ch1=%0d ch0=%0d, expected ch1=%0d ch0=%0d",
                             $signed(sample[31:16]), $signed(sample[15:0]),
                             $signed(mon_exp[31:16]), $signed(mon_exp[15:0]));
                end else begin
                    $display("[TB] round ok: ch1=%0d ch0=%0d",
                             $signed(sample[31:16]), $signed(sample[15:0]));
                end
            end
        end
    end

    function automatic logic [31:0] pack(input int v1, input int v0);
        logic [31:0] r;
        r = {v1[15:0], v0[15:0]};
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic set_ch(input int ch, input int kv, input int ov, input int mv);
        k[ch*PHASE_W +: PHASE_W]      = PHASE_W'(kv);
        offset[ch*PHASE_W +: PHASE_W] = PHASE_W'(ov);
        mode[ch*2 +: 2]               = 2'(mv);
    endtask

    task automatic wait_ready(output int cyc);
        logic got;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            got = new_sample_ready;
        end
    endtask

    // Entered and left one time unit after a rising edge, outside any ready cycle.
    task automatic do_round(input logic [31:0] expv, input logic clr);
        int cyc;
        sampling_pulse = 1'b1;
        phase_clr      = clr;
        exp_q.push_back(expv);
        pushes++;
        @(posedge clk); #1;
        sampling_pulse = 1'b0;
        phase_clr      = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        wait_ready(cyc);
        check("ready_latency", 64'(cyc), 64'd4);
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;

        // Reset held three cycles with the pulse toggling
        for (int i = 0; i < 3; i++) begin
            sampling_pulse = (i % 2 == 0);
            @(posedge clk); #1;
            check("rst_sample", 64'(sample), 64'd0);
            check("rst_ready", 64'(new_sample_ready), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_overrun", 64'(overrun), 64'd0);
        end
        sampling_pulse = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        do_round(pack(0, 0), 1'b0);

        // Sine quadrants on ch0
        set_ch(0, P20, 0, 0);
        set_ch(1, 0, 0, 0);
        do_round(pack(0, PK), 1'b0);
        do_round(pack(0, 0), 1'b0);
        do_round(pack(0, -PK), 1'b0);
        do_round(pack(0, 0), 1'b0);

        // Square, sawtooth and triangle on ch1
        set_ch(0, 0, 0, 0);
        set_ch(1, P20, 0, 1);
        do_round(pack(PK, 0), 1'b0);
        do_round(pack(-PK, 0), 1'b0);
        do_round(pack(-PK, 0), 1'b0);
        do_round(pack(PK, 0), 1'b0);
        set_ch(1, P21, 0, 2);
        do_round(pack(0, 0), 1'b0);
        do_round(pack(-32768, 0), 1'b0);
        set_ch(1, P20, 0, 3);
        do_round(pack(0, 0), 1'b0);
        do_round(pack(32767, 0), 1'b0);

        // Standalone clear brings ch1 (left at 2^21) back to zero
        phase_clr = 1'b1;
        @(posedge clk); #1;
        phase_clr = 1'b0;

        // Offsets with zero increment
        set_ch(0, 0, P21, 0);
        set_ch(1, 0, P21, 1);
        do_round(pack(-PK, 0), 1'b0);
        set_ch(0, 0, P20, 0);
        do_round(pack(-PK, PK), 1'b0);

        // Clear coincident with a start edge
        set_ch(0, P20, 0, 0);
        set_ch(1, 0, 0, 2);
        do_round(pack(-32768, PK), 1'b0);
        do_round(pack(-32768, PK), 1'b1);
        do_round(pack(-32768, 0), 1'b0);

        // Overrun: second pulse two cycles after the first is dropped
        check("overrun_before", 64'(overrun), 64'd0);
        sampling_pulse = 1'b1;
        exp_q.push_back(pack(-32768, -PK));
        pushes++;
        @(posedge clk); #1;
        sampling_pulse = 1'b0;
        @(posedge clk); #1;
        sampling_pulse = 1'b1;
        @(posedge clk); #1;
        sampling_pulse = 1'b0;
        check("overrun_set", 64'(overrun), 64'd1);
        wait_ready(cyc);
        check("overrun_ready_latency", 64'(cyc), 64'd2);
        @(posedge clk); #1;
        sampling_pulse = 1'b1;
        exp_q.push_back(pack(-32768, 0));
        pushes++;
        @(posedge clk); #1;
        sampling_pulse = 1'b0;
        check("accept_after_ready", 64'(busy), 64'd1);
        wait_ready(cyc);
        check("accept_latency", 64'(cyc), 64'd4);
        @(posedge clk); #1;
        check("overrun_sticky", 64'(overrun), 64'd1);

        // Reset asserted in the DRAIN cycle aborts the round
        sampling_pulse = 1'b1;
        @(posedge clk); #1;
        sampling_pulse = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_sample", 64'(sample), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(new_sample_ready), 64'd0);
        check("abort_overrun", 64'(overrun), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        check("abort_sample_held", 64'(sample), 64'd0);

        // Accumulators restart from zero after reset
        set_ch(0, P20, 0, 0);
        set_ch(1, 0, 0, 2);
        do_round(pack(-32768, PK), 1'b0);

        check("ready_count", 64'(ready_seen), 64'(pushes));
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_multi.md
# dds_multi

Time-multiplexed, parametrised direct digital synthesiser serving `CHANNELS` independent outputs from one shared quarter-wave `sine_rom`. Each channel has its own phase accumulator, phase increment, phase offset and waveform mode (sine, square, sawtooth, triangle). One `sampling_pulse` starts a round in which every channel is advanced and evaluated. The round ends with a single-cycle `new_sample_ready` and all samples updated together. The block sits between the sample-rate generator and the DAC/codec output path.

## Interface
- `CHANNELS`, 2: number of channels, 1..16.
- `PHASE_W`, 22: accumulator width, at least `ROM_AW+2`.
- `ROM_AW`, 10: quarter-wave ROM address width (1024 entries).
- `DATA_W`, 16: signed sample width; equals the `sine_rom` data width.

- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-low.
- `k` in `CHANNELS*PHASE_W`: per-channel phase increment; channel i occupies `[i*PHASE_W +: PHASE_W]`.
- `offset` in `CHANNELS*PHASE_W`: per-channel phase offset.
- `mode` in `CHANNELS*2`: per-channel waveform; 0 sine, 1 square, 2 sawtooth, 3 triangle.
- `sampling_pulse` in 1: one-cycle request to start a round.
- `phase_clr` in 1: synchronous clear of all accumulators.
- `sample` out `CHANNELS*DATA_W`: two's-complement samples, same packing as `k`.
- `new_sample_ready` out 1: one-cycle pulse when `sample` updates.
- `busy` out 1: a round is in progress.
- `overrun` out 1: sticky flag set when a `sampling_pulse` arrives while busy.

## Operation
- Reset (`reset`=0 at an edge):
  - `acc[*]`=0, `sample`=0, `new_sample_ready`=0, `busy`=0, `overrun`=0, FSM to IDLE.
  - A round in progress is aborted and produces no ready pulse.
- FSM states: IDLE, ISSUE, DRAIN, COMMIT.
  - IDLE→ISSUE on `sampling_pulse`.
  - ISSUE holds for `CHANNELS` cycles, with channel counter `ch` running 0..CHANNELS-1.
  - ISSUE→DRAIN, then DRAIN→COMMIT, then COMMIT→IDLE.
- At the start edge (pulse seen in IDLE):
  - `acc_i <= acc_i + k_i`, modulo 2^PHASE_W.
  - Snapshot `ph_i = acc_i + k_i + offset_i`, modulo 2^PHASE_W.
  - `mode` is snapshotted at the same edge.
- `phase_clr` is honoured at any time. If it coincides with a start edge, `acc_i <= k_i` and the snapshot uses `k_i + offset_i`. A round in progress always uses its snapshot.
- Sine mapping of `ph`:
  - `s` = bit PHASE_W-1, `q` = bit PHASE_W-2, `idx` = the next ROM_AW bits.
  - `q`=0: ROM address = `idx`.
  - `q`=1: ROM address = 2^ROM_AW − `idx`, except `idx`=0 gives 2^ROM_AW−1 (saturate).
  - Result = ROM value, negated (two's complement) when `s`=1.
- Square: +(2^(DATA_W−1)−1) when `s`=0, otherwise −(2^(DATA_W−1)−1).
- Sawtooth: top DATA_W bits of `ph` with the MSB inverted.
- Triangle:
  - `p` = top DATA_W+1 bits of `ph`.
  - `u` = `p[DATA_W-1:0]` if `p[DATA_W]`=0, else `~p[DATA_W-1:0]`.
  - Result = `u` with the MSB inverted.
- Non-sine modes still occupy their ROM slot; ROM data is ignored for them.
- Each result is written to shadow register `sh_i`. In COMMIT, `sample <= sh` for all channels at once and `new_sample_ready` pulses.
- A `sampling_pulse` while `busy`=1 is dropped and sets `overrun`. Only reset clears `overrun`.

## Timing
- Let E0 be the edge that samples `sampling_pulse` in IDLE.
- Channel i address is presented to the ROM during the cycle after E(i). ROM output registers at E(i+1), and `sh_i` is written at E(i+2).
- `sample` updates and `new_sample_ready`=1 after edge E(CHANNELS+2). Latency from E0 is CHANNELS+2 cycles; the pulse lasts exactly one cycle.
- `busy`=1 from after E0 through the ready cycle inclusive.
- A new pulse is accepted in the first cycle after the ready pulse. Back-to-back rounds run every CHANNELS+3 cycles.
- `sample` is stable between ready pulses.

## Structure
- `dds_pkg`: mode encoding constants (`MODE_SINE`, `MODE_SQUARE`, `MODE_SAW`, `MODE_TRI`) and the square amplitude constant.
- Sub-module `dds_wave_map` (combinational): phase, mode and ROM data in; ROM address and shaped sample out. It is instantiated once and shared.
- The existing `sine_rom` is instantiated once.
- Accumulators, snapshot, shadow and sample registers, and the FSM live in `dds_multi`.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `sampling_pulse` toggling -> all outputs 0, no ready pulse; release, then one pulse -> ready exactly 4 cycles after the start edge (CHANNELS=2).
- Sine quadrants: ch0 `k`=2^20, `offset`=0, mode 0; four rounds -> ROM addresses 1023, 0, 1023, 0 and samples +peak, 0, −peak, 0.
- Modes on ch1: `k`=2^20 -> square gives +32767, −32767, −32767, +32767; mode 2 at phase 0 gives −32768 and at 2^21 gives 0; mode 3 at phase 2^20 gives 0 and at 2^21 gives 32767.
- Offset and clear: `offset`=2^21 with `k`=0 -> sine 0 and square −32767; `phase_clr` coincident with a pulse, `k`=2^20 -> acc = 2^20 (not acc+k).
- Overrun: second pulse 2 cycles after the first -> dropped, `overrun`=1 and sticky, one ready pulse only; then a pulse the cycle after ready -> accepted.
- Reset mid-round: `reset`=0 in the DRAIN cycle -> no ready pulse, `sample`=0, `busy`=0 in the next cycle.
